// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall/flush vectors, PC redirect,
// load-use and memory-wait sequencing, sticky memory-timeout flag.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int unsigned LOAD_USE_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rs_id_ex_hit_i,
    input  logic        ex_is_load_i,
    input  logic        ex_jump_i,
    input  logic [63:0] ex_jump_addr_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic [4:0]  stall_o,
    output logic [4:0]  flush_o,
    output logic        jump_o,
    output logic [63:0] jump_addr_o,
    output logic        err_o,
    output logic [31:0] perf_lu_o,
    output logic [31:0] perf_mw_o,
    output logic [31:0] perf_fl_o
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax  = WaitW'(MEM_TIMEOUT);
    localparam logic [WaitW-1:0] WaitErr  = WaitW'(MEM_TIMEOUT - 1);
    localparam logic [3:0]       LuReload = 4'(LOAD_USE_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StLdUse, StMWait} state_e;

    state_e           state_q, state_d;
    logic [3:0]       lu_cnt_q, lu_cnt_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;

    logic        memwait, jump, loaduse;
    logic [4:0]  stall, flush;
    logic        jump_int;
    logic [63:0] jump_addr;

    // Prioritised event decode: memory wait > jump > load-use
    always_comb begin
        memwait = mem_req_i & ~mem_ready_i;
        jump    = ex_jump_i & ~memwait;
        loaduse = ~memwait & ~jump &
                  ((rs_id_ex_hit_i & ex_is_load_i) | (state_q == StLdUse && lu_cnt_q != 4'd0));
    end

    // Next-state, counter updates and raw stage-control outputs
    always_comb begin
        state_d    = state_q;
        lu_cnt_d   = lu_cnt_q;
        wait_cnt_d = '0;
        err_d      = err_q;
        stall      = 5'b00000;
        flush      = 5'b00000;
        jump_int   = 1'b0;
        jump_addr  = '0;
        if (memwait) begin
            stall   = 5'b01111;
            flush   = 5'b10000;
            state_d = StMWait;
            wait_cnt_d = (wait_cnt_q < WaitMax) ? wait_cnt_q + WaitW'(1) : wait_cnt_q;
            if (wait_cnt_q >= WaitErr) begin
                err_d = 1'b1;
            end
        end else if (jump) begin
            jump_int  = 1'b1;
            jump_addr = ex_jump_addr_i;
            flush     = 5'b00110;
            state_d   = StRun;
            lu_cnt_d  = 4'd0;
        end else if (loaduse) begin
            stall = 5'b00011;
            flush = 5'b00100;
            if (state_q == StLdUse) begin
                lu_cnt_d = lu_cnt_q - 4'd1;
                state_d  = (lu_cnt_q == 4'd1) ? StRun : StLdUse;
            end else begin
                lu_cnt_d = LuReload;
                state_d  = (LOAD_USE_CYCLES > 1) ? StLdUse : StRun;
            end
        end else begin
            // Release cycle out of a memory wait resumes any interrupted load-use
            state_d = (lu_cnt_q != 4'd0) ? StLdUse : StRun;
        end
    end

    // State, counters and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            lu_cnt_q   <= 4'd0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Outputs are forced quiet while reset is asserted
    assign stall_o     = rst_n ? stall : 5'b00000;
    assign flush_o     = rst_n ? flush : 5'b00000;
    assign jump_o      = rst_n & jump_int;
    assign jump_addr_o = rst_n ? jump_addr : 64'd0;
    assign err_o       = rst_n & err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_lu_q, perf_lu_d, perf_mw_q, perf_mw_d, perf_fl_q, perf_fl_d;

    // Saturating event counters
    always_comb begin
        perf_lu_d = perf_lu_q;
        perf_mw_d = perf_mw_q;
        perf_fl_d = perf_fl_q;
        if (loaduse && perf_lu_q != 32'hFFFF_FFFF) perf_lu_d = perf_lu_q + 32'd1;
        if (memwait && perf_mw_q != 32'hFFFF_FFFF) perf_mw_d = perf_mw_q + 32'd1;
        if (jump && perf_fl_q != 32'hFFFF_FFFF)    perf_fl_d = perf_fl_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_q <= 32'd0;
            perf_mw_q <= 32'd0;
            perf_fl_q <= 32'd0;
        end else begin
            perf_lu_q <= perf_lu_d;
            perf_mw_q <= perf_mw_d;
            perf_fl_q <= perf_fl_d;
        end
    end

    assign perf_lu_o = rst_n ? perf_lu_q : 32'd0;
    assign perf_mw_o = rst_n ? perf_mw_q : 32'd0;
    assign perf_fl_o = rst_n ? perf_fl_q : 32'd0;
`else
    assign perf_lu_o = 32'd0;
    assign perf_mw_o = 32'd0;
    assign perf_fl_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: two instances (3-cycle load-use with an
// 8-cycle timeout, and 1-cycle load-use with a 20-cycle timeout) share stimulus
// and are compared against a behavioural model of the hazard rules.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hit, ld, jmp, req, rdy;
    logic [63:0] jaddr;

    logic [4:0]  stall_a, flush_a, stall_b, flush_b;
    logic        jump_a, jump_b, err_a, err_b;
    logic [63:0] addr_a, addr_b;
    logic [31:0] plu_a, pmw_a, pfl_a, plu_b, pmw_b, pfl_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.LOAD_USE_CYCLES(3), .MEM_TIMEOUT(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rs_id_ex_hit_i(hit), .ex_is_load_i(ld),
        .ex_jump_i(jmp), .ex_jump_addr_i(jaddr), .mem_req_i(req), .mem_ready_i(rdy),
        .stall_o(stall_a), .flush_o(flush_a), .jump_o(jump_a), .jump_addr_o(addr_a),
        .err_o(err_a), .perf_lu_o(plu_a), .perf_mw_o(pmw_a), .perf_fl_o(pfl_a)
    );

    pipe_ctrl #(.LOAD_USE_CYCLES(1), .MEM_TIMEOUT(20)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rs_id_ex_hit_i(hit), .ex_is_load_i(ld),
        .ex_jump_i(jmp), .ex_jump_addr_i(jaddr), .mem_req_i(req), .mem_ready_i(rdy),
        .stall_o(stall_b), .flush_o(flush_b), .jump_o(jump_b), .jump_addr_o(addr_b),
        .err_o(err_b), .perf_lu_o(plu_b), .perf_mw_o(pmw_b), .perf_fl_o(pfl_b)
    );

    // A stage is never both held and bubbled
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            assert ((stall_a & flush_a) == 5'b0);
            assert ((stall_b & flush_b) == 5'b0);
        end
    end

    // Behavioural model: bubbles still owed, wait length, previous-cycle wait, error
    int          ml_lu_cycles[2] = '{3, 1};
    int          ml_timeout[2]   = '{8, 20};
    int          owed[2];
    int          waited[2];
    bit          was_wait[2];
    bit          m_err[2];
    logic [31:0] c_lu[2], c_mw[2], c_fl[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owed[k] = 0; waited[k] = 0; was_wait[k] = 0; m_err[k] = 0;
            c_lu[k] = 0; c_mw[k] = 0; c_fl[k] = 0;
        end
    endtask

    function automatic void decode(input int k, output bit mw, output bit j,
                                   output bit lu, output bit fresh);
        bit resume;
        mw     = req && !rdy;
        j      = jmp && !mw;
        resume = (owed[k] > 0) && !was_wait[k];
        lu     = !mw && !j && (resume || (hit && ld));
        fresh  = lu && !resume;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [171:0] exp_out(input int k);
        logic [4:0]  s, f;
        logic        jo;
        logic [63:0] a;
        logic [95:0] p;
        bit mw, j, lu, fresh;
        s = '0; f = '0; jo = 1'b0; a = '0; p = '0;
        decode(k, mw, j, lu, fresh);
        if (mw) begin
            s = 5'b01111; f = 5'b10000;
        end else if (j) begin
            jo = 1'b1; a = jaddr; f = 5'b00110;
        end else if (lu) begin
            s = 5'b00011; f = 5'b00100;
        end
`ifdef PIPE_CTRL_PERF_EN
        p = {c_lu[k], c_mw[k], c_fl[k]};
`endif
        if (rst_n !== 1'b1) return '0;
        return {s, f, jo, a, m_err[k], p};
    endfunction

    function automatic logic [171:0] got(input int k);
        if (k == 0) return {stall_a, flush_a, jump_a, addr_a, err_a, plu_a, pmw_a, pfl_a};
        return {stall_b, flush_b, jump_b, addr_b, err_b, plu_b, pmw_b, pfl_b};
    endfunction

    task automatic model_update();
        bit mw, j, lu, fresh;
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            decode(k, mw, j, lu, fresh);
            if (mw) begin
                if (waited[k] >= ml_timeout[k] - 1) m_err[k] = 1;
                if (waited[k] < ml_timeout[k]) waited[k]++;
                was_wait[k] = 1;
                c_mw[k] = sat_inc(c_mw[k]);
            end else begin
                waited[k]   = 0;
                was_wait[k] = 0;
                if (j) begin
                    owed[k] = 0;
                    c_fl[k] = sat_inc(c_fl[k]);
                end else if (lu) begin
                    c_lu[k] = sat_inc(c_lu[k]);
                    owed[k] = fresh ? ml_lu_cycles[k] - 1 : owed[k] - 1;
                end
            end
        end
    endtask

    // Clock edge plus model step; inputs change 1 time unit after the edge
    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic quiet();
        hit = 0; ld = 0; jmp = 0; jaddr = '0; req = 0; rdy = 0;
    endtask

    task automatic test_reset();
        hit = 1; ld = 1; jmp = 1; jaddr = 64'hDEAD_BEEF_0000_0004; req = 1; rdy = 0;
        #1;
        n_checks++;
        if (got(0) !== '0 || got(1) !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got a=%h b=%h, required all zero", got(0), got(1));
        end
        @(posedge clk);
        #1;
        quiet();
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got(k) !== exp_out(k)) begin
                n_errors++;
                $display("FAIL reset_idle dut%0d: got %h required %h", k, got(k), exp_out(k));
            end
        end
        advance();
    endtask

    task automatic test_load_use();
        int cnt_a = 0, cnt_b = 0;
        for (int c = 0; c < 5; c++) begin
            hit = (c == 0); ld = (c == 0);
            @(negedge clk);
            if (stall_a === 5'b00011) cnt_a++;
            if (stall_b === 5'b00011) cnt_b++;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got(k) !== exp_out(k)) begin
                    n_errors++;
                    $display("FAIL load_use dut%0d cyc%0d: got %h required %h",
                             k, c, got(k), exp_out(k));
                end
            end
            advance();
        end
        n_checks++;
        if (cnt_a != 3 || cnt_b != 1) begin
            n_errors++;
            $display("FAIL load_use_len: got a=%0d b=%0d, required a=3 b=1", cnt_a, cnt_b);
        end
`ifdef PIPE_CTRL_PERF_EN
        n_checks++;
        if (plu_a !== 32'd3 || plu_b !== 32'd1) begin
            n_errors++;
            $display("FAIL perf_lu: got a=%0d b=%0d, required a=3 b=1", plu_a, plu_b);
        end
`endif
        quiet();
    endtask

    task automatic test_jump();
        jmp = 1; jaddr = 64'h8000_0040;
        @(negedge clk);
        n_checks++;
        if (jump_a !== 1'b1 || addr_a !== 64'h8000_0040 || flush_a !== 5'b00110 ||
            stall_a !== 5'b0) begin
            n_errors++;
            $display("FAIL jump_basic: got j=%b addr=%h flush=%b stall=%b, required 1 80000040 00110 00000",
                     jump_a, addr_a, flush_a, stall_a);
        end
        advance();
        quiet();
        // Load-use, then a jump on the second bubble cycle
        for (int c = 0; c < 4; c++) begin
            hit = (c == 0); ld = (c == 0); jmp = (c == 1); jaddr = (c == 1) ? 64'h8000_0040 : '0;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got(k) !== exp_out(k)) begin
                    n_errors++;
                    $display("FAIL jump_abort dut%0d cyc%0d: got %h required %h",
                             k, c, got(k), exp_out(k));
                end
            end
            if (c == 2) begin
                n_checks++;
                if (stall_a !== 5'b0) begin
                    n_errors++;
                    $display("FAIL jump_abort_stall: got %b required 00000", stall_a);
                end
            end
            advance();
        end
        quiet();
    endtask

    task automatic test_mem_wait();
        req = 1; rdy = 0; jmp = 1; jaddr = 64'h0000_0000_1234_5678;
        for (int c = 0; c < 5; c++) begin
            rdy = (c == 4);
            @(negedge clk);
            n_checks++;
            if (c < 4 && (stall_a !== 5'b01111 || flush_a !== 5'b10000 || jump_a !== 1'b0)) begin
                n_errors++;
                $display("FAIL mem_wait cyc%0d: got stall=%b flush=%b j=%b, required 01111 10000 0",
                         c, stall_a, flush_a, jump_a);
            end else if (c == 4 && (stall_a !== 5'b0 || jump_a !== 1'b1 ||
                                    addr_a !== 64'h1234_5678)) begin
                n_errors++;
                $display("FAIL mem_release: got stall=%b j=%b addr=%h, required 00000 1 12345678",
                         stall_a, jump_a, addr_a);
            end
            n_checks++;
            if (got(1) !== exp_out(1)) begin
                n_errors++;
                $display("FAIL mem_wait dut1 cyc%0d: got %h required %h", c, got(1), exp_out(1));
            end
            advance();
        end
        quiet();
    endtask

    task automatic test_timeout();
        req = 1; rdy = 0;
        for (int i = 1; i <= 11; i++) begin
            rdy = (i == 11);
            @(negedge clk);
            n_checks++;
            if (err_a !== (i > 8) || err_b !== 1'b0) begin
                n_errors++;
                $display("FAIL timeout cyc%0d: got a=%b b=%b, required a=%b b=0",
                         i, err_a, err_b, (i > 8));
            end
            advance();
        end
        quiet();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got(k) !== exp_out(k)) begin
                n_errors++;
                $display("FAIL timeout_sticky dut%0d: got %h required %h", k, got(k), exp_out(k));
            end
        end
        advance();
    endtask

    task automatic test_async_reset();
        req = 1; rdy = 0; jmp = 1; jaddr = 64'hFFFF_0000_0000_0010;
        advance();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (got(0) !== '0 || got(1) !== '0) begin
            n_errors++;
            $display("FAIL async_reset: got a=%h b=%h, required all zero", got(0), got(1));
        end
        advance();
        rst_n = 1'b1;
        @(negedge clk);
        // Memory still waiting after release: hazard re-detected from inputs
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got(k) !== exp_out(k)) begin
                n_errors++;
                $display("FAIL post_reset dut%0d: got %h required %h", k, got(k), exp_out(k));
            end
        end
        n_checks++;
        if (err_a !== 1'b0 || stall_a !== 5'b01111) begin
            n_errors++;
            $display("FAIL post_reset_state: got err=%b stall=%b, required 0 01111", err_a, stall_a);
        end
        advance();
        quiet();
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            rst_n = 1'b1;
            hit   = ($urandom_range(0, 3) == 0);
            ld    = ($urandom_range(0, 1) == 0);
            jmp   = ($urandom_range(0, 7) == 0);
            jaddr = {$urandom, $urandom};
            req   = ($urandom_range(0, 2) == 0);
            rdy   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 24) == 0) begin
                req = 1; rdy = 0;
            end
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got(k) !== exp_out(k)) begin
                    n_errors++;
                    $display("FAIL random dut%0d cyc%0d: got %h required %h",
                             k, c, got(k), exp_out(k));
                end
            end
            advance();
        end
        rst_n = 1'b1;
        quiet();
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_jump();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
